// File: rtl/adc_pkg.sv
// Shared state encoding, defaults and record sizing for the ADC sample fetch front end.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_RDY  = 3'd3,
    ST_RELEASE   = 3'd4
  } adc_state_t;

  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 255;
  localparam int INDEX_W     = 32;

  // A FIFO record is {conversion index, sample}.
  function automatic int sample_rec_w(input int data_w);
    return INDEX_W + data_w;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with full/empty flags; a pop in the same cycle frees room for a push when full.
module sample_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];

endmodule

// File: rtl/adc_sample_fetch.sv
// Paces ADC conversions, runs the four-phase req/rdy handshake and streams
// {index, sample} records out through a small FIFO with sticky fault flags.
module adc_sample_fetch
  import adc_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PERIOD_W   = 16,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clr_err,
  output logic                adc_req,
  input  logic                adc_rdy,
  input  logic [DATA_W-1:0]   adc_dat,
  output logic                smp_valid,
  input  logic                smp_ready,
  output logic [DATA_W-1:0]   smp_data,
  output logic [INDEX_W-1:0]  smp_index,
  output logic                busy,
  output logic                timeout_err,
  output logic                overrun,
  output logic                missed_tick
);

  localparam int REC_W = sample_rec_w(DATA_W);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  adc_state_t          r_state;
  adc_state_t          w_state_nxt;
  logic                r_rdy_p0;
  logic                r_rdy_p1;
  logic [PERIOD_W-1:0] r_tick_cnt;
  logic [PERIOD_W-1:0] w_period_m1;
  logic [TO_W-1:0]     r_to_cnt;
  logic [INDEX_W-1:0]  r_index;
  logic                r_adc_req;
  logic                r_timeout_err;
  logic                r_overrun;
  logic                r_missed_tick;
  logic                w_tick;
  logic                w_capture;
  logic                w_timeout;
  logic                w_missed;
  logic                w_drop;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [REC_W-1:0]    w_rec_in;
  logic [REC_W-1:0]    w_rec_out;

  // adc_rdy is asynchronous: two flops before any decision uses it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdy_p0 <= 1'b0;
      r_rdy_p1 <= 1'b0;
    end else begin
      r_rdy_p0 <= adc_rdy;
      r_rdy_p1 <= r_rdy_p0;
    end
  end

  // A period of 0 behaves as 1; >= keeps the counter sane if period shrinks mid-count.
  assign w_period_m1 = (period == '0) ? '0 : period - 1'b1;
  assign w_tick      = enable && (r_state != ST_IDLE) && (r_tick_cnt >= w_period_m1);
  assign w_missed    = w_tick && (r_state != ST_IDLE) && (r_state != ST_WAIT_TICK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_tick_cnt <= '0;
    end else if (enable) begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_state_nxt = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (!enable)     w_state_nxt = ST_IDLE;
        else if (w_tick) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        w_state_nxt = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (r_rdy_p1) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RELEASE;
        end else if (r_to_cnt >= TO_W'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Enable is only consulted once the ADC has dropped rdy.
        if (!r_rdy_p1) w_state_nxt = enable ? ST_WAIT_TICK : ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_adc_req <= 1'b0;
      r_to_cnt  <= '0;
      r_index   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_REQ)          r_adc_req <= 1'b1;
      else if (w_capture || w_timeout) r_adc_req <= 1'b0;
      if (r_state == ST_REQ)
        r_to_cnt <= '0;
      else if (r_state == ST_WAIT_RDY && !w_capture && !w_timeout)
        r_to_cnt <= r_to_cnt + 1'b1;
      if (w_capture) r_index <= r_index + 1'b1;
    end
  end

  // When full, a capture is dropped unless the consumer pops in the same cycle.
  assign w_drop = w_capture && w_fifo_full && !smp_ready;

  // Sticky flags: a set in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timeout_err <= 1'b0;
      r_overrun     <= 1'b0;
      r_missed_tick <= 1'b0;
    end else begin
      if (w_timeout)    r_timeout_err <= 1'b1;
      else if (clr_err) r_timeout_err <= 1'b0;
      if (w_drop)       r_overrun <= 1'b1;
      else if (clr_err) r_overrun <= 1'b0;
      if (w_missed)     r_missed_tick <= 1'b1;
      else if (clr_err) r_missed_tick <= 1'b0;
    end
  end

  assign w_rec_in = {r_index, adc_dat};

  sample_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_capture),
    .i_wdata (w_rec_in),
    .i_pop   (smp_ready),
    .o_rdata (w_rec_out),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Head is masked while empty so the unreset storage never leaks out.
  assign {smp_index, smp_data} = w_fifo_empty ? '0 : w_rec_out;
  assign smp_valid   = !w_fifo_empty;
  assign adc_req     = r_adc_req;
  assign busy        = (r_state != ST_IDLE);
  assign timeout_err = r_timeout_err;
  assign overrun     = r_overrun;
  assign missed_tick = r_missed_tick;

endmodule

// File: tb/tb_adc_sample_fetch.sv
// Directed bench for adc_sample_fetch with a behavioural four-phase ADC model.
module tb_adc_sample_fetch;

  localparam int DATA_W     = 8;
  localparam int PERIOD_W   = 16;
  localparam int TIMEOUT    = 255;
  localparam int FIFO_DEPTH = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic [PERIOD_W-1:0] period;
  logic                clr_err;
  logic                adc_req;
  logic                adc_rdy = 1'b0;
  logic [DATA_W-1:0]   adc_dat = 8'hEE;
  logic                smp_valid;
  logic                smp_ready;
  logic [DATA_W-1:0]   smp_data;
  logic [31:0]         smp_index;
  logic                busy;
  logic                timeout_err;
  logic                overrun;
  logic                missed_tick;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int mdl_lat   = 3;
  bit mdl_mute  = 1'b0;
  int mdl_epoch = 0;
  bit proto_on  = 1'b0;
  int mdl_seen_epoch = 0;
  int mdl_cnt   = 0;
  int mdl_nconv = 0;
  int proto_evt = 0;
  int proto_bad = 0;
  logic mdl_prev_req = 1'b0;

  typedef struct {
    int period;
    int lat;
    int spacing;
    bit missed;
  } vec_t;
  vec_t vecs[6];

  adc_sample_fetch #(
    .DATA_W     (DATA_W),
    .PERIOD_W   (PERIOD_W),
    .TIMEOUT    (TIMEOUT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .period      (period),
    .clr_err     (clr_err),
    .adc_req     (adc_req),
    .adc_rdy     (adc_rdy),
    .adc_dat     (adc_dat),
    .smp_valid   (smp_valid),
    .smp_ready   (smp_ready),
    .smp_data    (smp_data),
    .smp_index   (smp_index),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun     (overrun),
    .missed_tick (missed_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] adc_val(input int k);
    return 8'h5A + 8'(k * 37);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC: raises rdy mdl_lat cycles after seeing req, holds until req falls.
  always @(negedge clk) begin
    if (proto_on && adc_req && !mdl_prev_req) begin
      proto_evt++;
      if (adc_rdy) proto_bad++;
    end
    if (proto_on && !adc_req && mdl_prev_req) begin
      proto_evt++;
      if (!adc_rdy) proto_bad++;
    end
    mdl_prev_req = adc_req;
    if (mdl_seen_epoch != mdl_epoch) begin
      mdl_seen_epoch = mdl_epoch;
      mdl_cnt   = 0;
      mdl_nconv = 0;
      proto_evt = 0;
      proto_bad = 0;
      adc_rdy   = 1'b0;
      adc_dat   = 8'hEE;
    end else if (mdl_mute) begin
      adc_rdy = 1'b0;
      mdl_cnt = 0;
    end else if (adc_req && !adc_rdy) begin
      mdl_cnt++;
      if (mdl_cnt >= mdl_lat) begin
        adc_rdy = 1'b1;
        adc_dat = adc_val(mdl_nconv);
      end
    end else if (!adc_req && adc_rdy) begin
      adc_rdy = 1'b0;
      adc_dat = 8'hEE;
      mdl_cnt = 0;
      mdl_nconv++;
    end else if (!adc_req) begin
      mdl_cnt = 0;
    end
  end

  task automatic do_reset();
    proto_on  = 1'b0;
    enable    = 1'b0;
    clr_err   = 1'b0;
    smp_ready = 1'b0;
    reset     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mdl_epoch++;
    @(negedge clk);
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (smp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_req(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (adc_req) break;
    end
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int prev;
    int len;
    int n_req;
    int n_val;
    bit saw;

    vecs[0] = '{period: 10, lat: 3, spacing: 10, missed: 1'b0};
    vecs[1] = '{period: 20, lat: 3, spacing: 20, missed: 1'b0};
    vecs[2] = '{period: 0,  lat: 3, spacing: 10, missed: 1'b1};
    vecs[3] = '{period: 1,  lat: 3, spacing: 10, missed: 1'b1};
    vecs[4] = '{period: 4,  lat: 3, spacing: 12, missed: 1'b1};
    vecs[5] = '{period: 12, lat: 6, spacing: 24, missed: 1'b1};

    reset = 1'b0; enable = 1'b0; clr_err = 1'b0; smp_ready = 1'b0; period = '0;
    repeat (2) @(negedge clk);
    chk("rst_adc_req", adc_req, 0);
    chk("rst_smp_valid", smp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_missed_tick", missed_tick, 0);
    chk("rst_smp_index", smp_index, 0);
    chk("rst_smp_data", smp_data, 0);

    // Pacing / handshake vectors
    for (int v = 0; v < 6; v++) begin
      do_reset();
      period    = PERIOD_W'(vecs[v].period);
      mdl_lat   = vecs[v].lat;
      mdl_mute  = 1'b0;
      smp_ready = 1'b1;
      proto_on  = 1'b1;
      enable    = 1'b1;
      prev      = 0;
      for (int s = 0; s < 3; s++) begin
        wait_valid(3 * vecs[v].spacing + 30, ok);
        chk($sformatf("v%0d_s%0d_seen", v, s), ok, 1);
        if (!ok) break;
        chk($sformatf("v%0d_s%0d_index", v, s), smp_index, s);
        chk($sformatf("v%0d_s%0d_data", v, s), smp_data, adc_val(s));
        if (s > 0) chk($sformatf("v%0d_s%0d_spacing", v, s), cyc - prev, vecs[v].spacing);
        prev = cyc;
      end
      chk($sformatf("v%0d_missed_tick", v), missed_tick, vecs[v].missed);
      chk($sformatf("v%0d_timeout_err", v), timeout_err, 0);
      chk($sformatf("v%0d_overrun", v), overrun, 0);
      enable = 1'b0;
      wait_idle(40);
      chk($sformatf("v%0d_idle", v), busy, 0);
      chk($sformatf("v%0d_proto_edges", v), proto_evt, 6);
      chk($sformatf("v%0d_proto_bad", v), proto_bad, 0);
    end

    // ADC never answers
    do_reset();
    period = 16'd10; mdl_mute = 1'b1; smp_ready = 1'b1; enable = 1'b1;
    wait_req(60);
    chk("to_req_rise", adc_req, 1);
    len = 0; saw = 1'b0;
    while (adc_req && len < 400) begin
      len++;
      if (smp_valid) saw = 1'b1;
      @(negedge clk);
    end
    chk("to_req_high_cycles", len, TIMEOUT);
    chk("to_timeout_err", timeout_err, 1);
    chk("to_no_valid", saw, 0);
    mdl_mute = 1'b0;
    wait_valid(60, ok);
    chk("to_next_seen", ok, 1);
    chk("to_next_index", smp_index, 0);
    chk("to_next_data", smp_data, adc_val(0));
    chk("to_err_sticky", timeout_err, 1);
    enable = 1'b0;
    wait_idle(40);
    pulse_clr();
    chk("to_err_cleared", timeout_err, 0);

    // FIFO overflow and drain
    do_reset();
    period = 16'd10; mdl_lat = 3; smp_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mdl_nconv >= 6) break;
    end
    chk("ovr_six_conversions", mdl_nconv, 6);
    enable = 1'b0;
    wait_idle(30);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid", smp_valid, 1);
    chk("ovr_missed", missed_tick, 0);
    smp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovr_drain%0d_valid", k), smp_valid, 1);
      chk($sformatf("ovr_drain%0d_index", k), smp_index, k);
      chk($sformatf("ovr_drain%0d_data", k), smp_data, adc_val(k));
      @(negedge clk);
    end
    chk("ovr_drained_empty", smp_valid, 0);
    enable = 1'b1;
    wait_valid(60, ok);
    chk("ovr_next_seen", ok, 1);
    chk("ovr_next_index", smp_index, 6);
    chk("ovr_next_data", smp_data, adc_val(6));
    chk("ovr_flag_persists", overrun, 1);
    enable = 1'b0;
    wait_idle(40);
    pulse_clr();
    chk("ovr_flag_cleared", overrun, 0);

    // Enable dropped mid-handshake
    do_reset();
    period = 16'd10; mdl_lat = 6; smp_ready = 1'b1; enable = 1'b1;
    wait_req(40);
    chk("en_req_rise", adc_req, 1);
    enable = 1'b0;
    wait_valid(30, ok);
    chk("en_sample_seen", ok, 1);
    chk("en_sample_index", smp_index, 0);
    chk("en_sample_data", smp_data, adc_val(0));
    wait_idle(20);
    chk("en_busy_fell", busy, 0);
    chk("en_rdy_low_at_idle", adc_rdy, 0);
    n_req = 0; n_val = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (adc_req) n_req++;
      if (smp_valid) n_val++;
    end
    chk("en_no_more_req", n_req, 0);
    chk("en_no_more_valid", n_val, 0);

    // Reset while adc_req is high
    do_reset();
    period = 16'd10; mdl_lat = 3; smp_ready = 1'b0; enable = 1'b1;
    wait_valid(40, ok);
    chk("rr_first_buffered", ok, 1);
    for (int i = 0; i < 30; i++) begin
      if (adc_req) break;
      @(negedge clk);
    end
    chk("rr_second_req", adc_req, 1);
    reset = 1'b0;
    #1;
    chk("rr_req_dropped", adc_req, 0);
    chk("rr_valid_cleared", smp_valid, 0);
    chk("rr_busy_cleared", busy, 0);
    @(negedge clk);
    mdl_epoch++;
    @(negedge clk);
    smp_ready = 1'b1;
    reset = 1'b1;
    wait_valid(60, ok);
    chk("rr_after_seen", ok, 1);
    chk("rr_after_index", smp_index, 0);
    chk("rr_after_data", smp_data, adc_val(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
